fetch_unit_pf: RTL and testbench

- Parametrised instruction fetch unit for the RISCV_Processor core; successor to the fixed single-select PC/instruction path.
- Generates the PC, issues requests to a synchronous-read instruction memory, and buffers returned instructions with their PCs in a prefetch FIFO.
- Supports pipeline back-pressure, redirect (branch/jump) with flush and in-flight discard, and a halt state on misaligned redirect.
- Sits between instruction memory and the decode stage.

---
 rtl/fetch_unit_pf.sv | 99 +++++++++
 tb/tb_fetch_unit_pf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pf.sv
// Instruction fetch unit: PC generation, synchronous-read imem requests and a
// prefetch FIFO of {pc, instruction}. Supports redirect, flush and halt.
module fetch_unit_pf #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_AW    = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_instruction,
    output logic               halted
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pc_q;
    logic            r_inflight;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_instr [FIFO_DEPTH];

    logic [CW-1:0]   w_occupancy;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_redir_misaligned;
    logic [XLEN-1:0] w_redir_target;

    // Occupancy counts the outstanding request so the FIFO can never overflow.
    assign w_occupancy        = r_count + CW'(r_inflight);
    assign w_issue            = !reset && !redirect_valid && (r_state == ST_RUN)
                                && (w_occupancy < CW'(FIFO_DEPTH));
    assign w_push             = !reset && !redirect_valid && r_inflight;
    assign w_pop              = !reset && !redirect_valid && out_valid && out_ready;
    assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_redir_target     = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_pc_q     <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_valid) begin
                // Flush wins over any pop or push in the same cycle.
                r_state    <= w_redir_misaligned ? ST_HALT : ST_RUN;
                r_fetch_pc <= w_redir_target;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                    r_pc_q     <= r_fetch_pc;
                end
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pc_q;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req        = w_issue;
    assign imem_addr       = r_fetch_pc[IMEM_AW+1:2];
    assign out_valid       = (r_count != '0);
    assign out_pc          = out_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign out_instruction = out_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign halted          = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Bench for fetch_unit_pf: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit_pf;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    fetch_unit_pf #(
        .XLEN(32), .IMEM_AW(8), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instruction(out_instruction),
        .halted(halted)
    );

    // Synchronous-read instruction memory
    always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return 32'h1000_0000 + {24'h0, pc[9:2]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as a queue of PCs
    logic [31:0] m_q[$];
    logic [31:0] m_pc      = 32'h0;
    bit          m_pend    = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    bit          m_halt    = 1'b0;

    always @(negedge clk) begin : model
        bit          e_req;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0] : 32'h0;
        e_instr = e_valid ? instr_of(m_q[0]) : 32'h0;
        e_req   = !reset && !redirect_valid && !m_halt
                  && ((m_q.size() + int'(m_pend)) < FIFO_DEPTH);
        if (chk_en) begin
            chk("m_req",    {31'h0, imem_req},  {31'h0, e_req});
            chk("m_addr",   {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
            chk("m_valid",  {31'h0, out_valid}, {31'h0, e_valid});
            chk("m_pc",     out_pc,             e_pc);
            chk("m_instr",  out_instruction,    e_instr);
            chk("m_halted", {31'h0, halted},    {31'h0, m_halt});
            n_tests++;
            if (dut.r_count > 3'(FIFO_DEPTH)) begin
                n_fail++;
                $display("FAIL count_bound: count=%0d, limit=%0d", dut.r_count, FIFO_DEPTH);
            end
            if (out_valid && out_ready && !redirect_valid && !reset)
                $display("[TB] pop pc=%h instr=%h", out_pc, out_instruction);
        end
        if (reset) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_pend = 1'b0;
            m_halt = 1'b0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = {redirect_pc[31:2], 2'b00};
            m_halt = (redirect_pc[1:0] != 2'b00);
        end else begin
            if (e_valid && out_ready) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            m_pend = e_req;
            if (e_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;

        // Reset state
        reset = 1'b1; out_ready = 1'b1;
        tick(); chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req",    {31'h0, imem_req},  32'h0);
        chk("rst_valid",  {31'h0, out_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted},    32'h0);
        chk("rst_pc",     out_pc,             32'h0);
        chk("rst_instr",  out_instruction,    32'h0);

        // Streaming after reset release: out_valid from cycle 2, one per cycle
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("t1_c0_req",  {31'h0, imem_req},  32'h1);
        chk("t1_c0_addr", {24'h0, imem_addr}, 32'h0);
        tick(); @(negedge clk);
        chk("t1_c1_valid", {31'h0, out_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); @(negedge clk);
            chk($sformatf("t1_valid%0d", k), {31'h0, out_valid}, 32'h1);
            chk($sformatf("t1_pc%0d", k),    out_pc,             32'(4 * k));
            chk($sformatf("t1_instr%0d", k), out_instruction,    32'h1000_0000 + 32'(k));
        end

        // Stall: FIFO fills to depth, then drains in order and streaming resumes
        tick(); reset = 1'b1; out_ready = 1'b0;
        tick(); reset = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        chk("t2_full_req",   {31'h0, imem_req},  32'h0);
        chk("t2_full_valid", {31'h0, out_valid}, 32'h1);
        tick(); out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t2_valid%0d", k), {31'h0, out_valid}, 32'h1);
            chk($sformatf("t2_pc%0d", k),    out_pc,             32'(4 * k));
            if (k == 0) chk("t2_drain_req", {31'h0, imem_req}, 32'h0);
            tick();
        end

        // Redirect with 3 buffered entries and one request in flight
        reset = 1'b1; out_ready = 1'b0;
        tick(); reset = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        chk("t3_r_req", {31'h0, imem_req}, 32'h0);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t3_r1_req",   {31'h0, imem_req},  32'h1);
        chk("t3_r1_addr",  {24'h0, imem_addr}, 32'h10);
        chk("t3_r1_valid", {31'h0, out_valid}, 32'h0);
        tick(); @(negedge clk);
        chk("t3_r2_valid", {31'h0, out_valid}, 32'h0);
        tick(); @(negedge clk);
        chk("t3_r3_valid", {31'h0, out_valid}, 32'h1);
        chk("t3_r3_pc",    out_pc,             32'h40);
        chk("t3_r3_instr", out_instruction,    32'h1000_0010);

        // Redirect coincident with a pop: flush wins
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("t4_r_valid", {31'h0, out_valid}, 32'h1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_r1_valid", {31'h0, out_valid}, 32'h0);
        tick(); tick(); @(negedge clk);
        chk("t4_r3_pc", out_pc, 32'h100);

        // Misaligned redirect halts; aligned redirect resumes
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        chk("t5_r_req", {31'h0, imem_req}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); redirect_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t5_halted%0d", k), {31'h0, halted},    32'h1);
            chk($sformatf("t5_req%0d", k),    {31'h0, imem_req},  32'h0);
            chk($sformatf("t5_valid%0d", k),  {31'h0, out_valid}, 32'h0);
        end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        chk("t5_exit_halted", {31'h0, halted}, 32'h1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_run_halted", {31'h0, halted},    32'h0);
        chk("t5_run_req",    {31'h0, imem_req},  32'h1);
        chk("t5_run_addr",   {24'h0, imem_addr}, 32'h20);
        tick(); tick(); @(negedge clk);
        chk("t5_run_pc",    out_pc,          32'h80);
        chk("t5_run_instr", out_instruction, 32'h1000_0020);

        // Word-address wrap past 0x3FC, then reset mid-stream
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h3F0;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_addr_fc", {24'h0, imem_addr}, 32'hFC);
        repeat (4) tick();
        @(negedge clk);
        chk("t6_wrap_req",  {31'h0, imem_req},  32'h1);
        chk("t6_wrap_addr", {24'h0, imem_addr}, 32'h0);
        tick(); tick(); @(negedge clk);
        chk("t6_pc_400",    out_pc,          32'h400);
        chk("t6_instr_400", out_instruction, 32'h1000_0000);
        tick(); reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("t6_post_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_post_pc",    out_pc,             32'h0);
        chk("t6_post_instr", out_instruction,    32'h0);
        chk("t6_post_halt",  {31'h0, halted},    32'h0);
        chk("t6_post_addr",  {24'h0, imem_addr}, 32'h0);
        chk("t6_post_req",   {31'h0, imem_req},  32'h1);
        tick(); tick(); @(negedge clk);
        chk("t6_restart_pc",    out_pc,          32'h0);
        chk("t6_restart_instr", out_instruction, 32'h1000_0000);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
